uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the low-power UART. It detects the start condition on the serial line and drives the oversampling edge counter that sequences the majority-vote data sampler. It walks the frame through start, data, optional parity and stop bits, assembling the byte LSB-first. It reports the byte with a one-cycle valid pulse and flags parity and stop errors. It sits between the RX pad synchroniser and the data sampler, and feeds the RX FIFO/register interface.

## Interface
- DATA_WIDTH, 8, payload bits per frame
- CLK  in  1  oversampling clock (Prescale × baud)
- Reset  in  1  asynchronous, active-low reset
- RX_IN  in  1  synchronised serial line, idle high
- Prescale  in  5  clocks per bit; legal 5..31; must be stable while not IDLE
- PAR_EN  in  1  1 = parity bit present
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at parity check
- sampled  in  1  sampler pulse: Sampled_bit valid this cycle
- Sampled_bit  in  1  majority-voted bit from sampler
- S_EN  out  1  sampler enable; high in every state except IDLE
- edge_count  out  5  clock index within current bit, 0..Prescale-1
- P_DATA  out  DATA_WIDTH  last accepted byte; holds until next good frame
- Data_valid  out  1  one-cycle pulse, P_DATA updated same cycle
- Par_err  out  1  one-cycle pulse at frame end on parity mismatch
- Stp_err  out  1  one-cycle pulse at frame end on stop bit = 0

## Operation
- Reset values are all zero: state IDLE, edge_count 0, bit counter 0, shift register 0, P_DATA 0, all pulses 0, S_EN 0.
- States: IDLE, START, DATA, PARITY, STOP. S_EN is decoded from the registered state.
- IDLE: counters are held at 0. RX_IN == 0 goes to START.
- Edge counter: increments every cycle while not IDLE. At Prescale-1 it wraps to 0 and the bit counter increments. Both clear on every entry to IDLE.
- START: a sampled pulse with Sampled_bit == 1 is a glitch. The block goes to IDLE next cycle with no output pulse. Otherwise, at the edge_count wrap, it goes to DATA.
- DATA: each sampled pulse shifts Sampled_bit into the MSB of the shift register with a right shift, so bit 0 arrives first. After the wrap of data bit DATA_WIDTH-1, the block goes to PARITY if PAR_EN, else to STOP.
- PARITY: on the sampled pulse, the expected bit is computed over the shift register. Even parity is ^shift and odd parity is ~^shift. A mismatch sets the internal par_fail flag. At the wrap, the block goes to STOP.
- STOP: on the sampled pulse, the block goes to IDLE next cycle and does not wait for the bit end, which allows back-to-back frames. In that IDLE cycle:
  - stop bit = 0: Stp_err pulses.
  - par_fail set: Par_err pulses.
  - Both are independent and may pulse together.
  - Neither error: Data_valid pulses and P_DATA loads the shift register.
  - Any error: P_DATA is unchanged.
- par_fail clears on entry to START.
- RX_IN low in the same cycle a frame returns to IDLE is not missed: that IDLE cycle evaluates RX_IN normally.
- Reset asserted mid-frame returns everything to reset values immediately, with no pulses.
- Width rules: the edge wrap compare is edge_count == Prescale-1, done in 5 bits. The bit counter is $clog2(DATA_WIDTH+3) bits.

## Timing
- Cycle 0 is the first START cycle (edge_count 0). It follows the clock edge on which IDLE saw RX_IN = 0.
- The sampler raises sampled when edge_count == Prescale/2+2. Prescale ≥ 5 keeps this at or before Prescale-1.
- Frame latency from cycle 0 to Data_valid:
  - Without parity: (1+DATA_WIDTH)·Prescale + Prescale/2 + 3.
  - With parity: add Prescale.
- For Prescale 8, 8N1: the stop sample is at cycle 78 and Data_valid at cycle 79.
- All outputs are registered except S_EN, which is state-decoded.

## Structure
- Package uart_rx_pkg: state enum (IDLE=0 … STOP=4, 3-bit), PAR_EVEN=0, PAR_ODD=1, and the DATA_WIDTH default.
- Sub-module edge_bit_counter: edge and bit counters with enable, wrap on Prescale-1, and synchronous clear. The FSM, shift register, parity check and output pulses live in uart_rx_ctrl.

## Test plan
- Prescale 8, PAR_EN 0, byte 0xA5, stop 1 → Data_valid at cycle 79, P_DATA = 0xA5, no errors.
- Prescale 8, PAR_EN 1, PAR_TYP 0, byte 0x0F, parity bit 1 → Par_err pulse, P_DATA keeps its previous value. With parity bit 0, Data_valid pulses with P_DATA = 0x0F.
- Prescale 5, odd parity, byte 0x80, parity 0, stop 0 → Stp_err only.
- Start glitch: RX_IN low for 2 cycles at Prescale 8 → back to IDLE, S_EN low, no pulses.
- Back-to-back frames 0x55 then 0xC3, next start bit immediately after the stop sample → two Data_valid pulses with the correct bytes.
- Reset asserted mid-DATA → all outputs 0 immediately. A clean frame after release is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversampling edge counter and bit counter; the edge counter wraps at
// prescale-1 and each wrap advances the bit counter.
module edge_bit_counter #(
   parameter int BIT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [4:0]       prescale,
   output logic [4:0]       edge_count,
   output logic [BIT_W-1:0] bit_count,
   output logic             wrap
);

   assign wrap = en && (edge_count == (prescale - 5'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (clr) begin
         edge_count <= '0;
         bit_count  <= '0;
      end else if (en) begin
         if (wrap) begin
            edge_count <= '0;
            bit_count  <= bit_count + 1'b1;
         end else begin
            edge_count <= edge_count + 5'd1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: walks start/data/parity/stop, assembles the byte
// LSB-first and reports it with a valid pulse or parity/stop error pulses.
//
// state  | meaning
// IDLE   | line idle, counters held at 0, waiting for RX_IN low
// START  | start bit; a sampled 1 is a glitch and aborts the frame
// DATA   | shifting in DATA_WIDTH sampled bits, LSB first
// PARITY | checking the parity bit against the assembled byte
// STOP   | waiting for the stop sample, then report and return to IDLE
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  RX_IN,
   input  logic [4:0]            Prescale,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  sampled,
   input  logic                  Sampled_bit,
   output logic                  S_EN,
   output logic [4:0]            edge_count,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_valid,
   output logic                  Par_err,
   output logic                  Stp_err
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 3);

   rx_state_t             state;
   logic [DATA_WIDTH-1:0] shift;
   logic                  par_fail;
   logic [BIT_W-1:0]      bit_count;
   logic                  wrap;
   logic                  to_idle;
   logic                  cnt_clr;
   logic                  exp_par;
   logic                  last_data;

   assign S_EN = (state != IDLE);

   // Counters clear on the same edge that enters IDLE so a back-to-back
   // start bit sees edge_count 0 in its first START cycle.
   assign to_idle   = sampled && (((state == START) && Sampled_bit) || (state == STOP));
   assign cnt_clr   = (state == IDLE) || to_idle;
   assign exp_par   = (PAR_TYP == PAR_ODD) ? ~^shift : ^shift;
   assign last_data = (bit_count == BIT_W'(DATA_WIDTH));

   edge_bit_counter #(
      .BIT_W (BIT_W)
   ) u_cnt (
      .clk        (CLK),
      .rst_n      (Reset),
      .en         (S_EN),
      .clr        (cnt_clr),
      .prescale   (Prescale),
      .edge_count (edge_count),
      .bit_count  (bit_count),
      .wrap       (wrap)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         shift      <= '0;
         par_fail   <= 1'b0;
         P_DATA     <= '0;
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stp_err    <= 1'b0;
      end else begin
         Data_valid <= 1'b0;
         Par_err    <= 1'b0;
         Stp_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!RX_IN) begin
                  state    <= START;
                  par_fail <= 1'b0;
               end
            end
            START: begin
               if (sampled && Sampled_bit) state <= IDLE;
               else if (wrap)              state <= DATA;
            end
            DATA: begin
               if (sampled) shift <= {Sampled_bit, shift[DATA_WIDTH-1:1]};
               if (wrap && last_data) state <= PAR_EN ? PARITY : STOP;
            end
            PARITY: begin
               if (sampled && (Sampled_bit != exp_par)) par_fail <= 1'b1;
               if (wrap) state <= STOP;
            end
            STOP: begin
               if (sampled) begin
                  state   <= IDLE;
                  Stp_err <= ~Sampled_bit;
                  Par_err <= par_fail;
                  if (Sampled_bit && !par_fail) begin
                     Data_valid <= 1'b1;
                     P_DATA     <= shift;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: drives whole frames on RX_IN, emulates the
// majority-vote sampler from its own cycle count and checks the result pulses.
module tb_uart_rx_ctrl;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic       RX_IN = 1'b1;
   logic [4:0] Prescale = 5'd8;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic       sampled = 1'b0;
   logic       Sampled_bit = 1'b1;
   logic       S_EN;
   logic [4:0] edge_count;
   logic [7:0] P_DATA;
   logic       Data_valid;
   logic       Par_err;
   logic       Stp_err;

   int         n_chk = 0;
   int         n_bad = 0;
   logic [7:0] model_pdata = 8'h00;

   uart_rx_ctrl dut (
      .CLK         (CLK),
      .Reset       (Reset),
      .RX_IN       (RX_IN),
      .Prescale    (Prescale),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .sampled     (sampled),
      .Sampled_bit (Sampled_bit),
      .S_EN        (S_EN),
      .edge_count  (edge_count),
      .P_DATA      (P_DATA),
      .Data_valid  (Data_valid),
      .Par_err     (Par_err),
      .Stp_err     (Stp_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk_val({tag, "_sen"},  32'(S_EN),       32'd0);
      chk_val({tag, "_edge"}, 32'(edge_count), 32'd0);
      chk_val({tag, "_pdat"}, 32'(P_DATA),     32'd0);
      chk_val({tag, "_dv"},   32'(Data_valid), 32'd0);
      chk_val({tag, "_pe"},   32'(Par_err),    32'd0);
      chk_val({tag, "_se"},   32'(Stp_err),    32'd0);
   endtask

   task automatic idle_cycles(input int n);
      RX_IN = 1'b1;
      sampled = 1'b0;
      Sampled_bit = 1'b1;
      repeat (n) @(negedge CLK);
   endtask

   // Called at a negedge in an IDLE cycle; leaves at the negedge of the IDLE
   // cycle carrying the result pulses. abort_at >= 0 asserts reset at that cycle.
   task automatic run_frame(input string tag, input logic [7:0] data, input logic pbit,
                            input logic sbit, input int abort_at);
      logic bits [0:10];
      int   p, nb, lat, stray;
      logic exp_pe, exp_se, exp_dv;
      p = int'(Prescale);
      for (int i = 0; i <= 10; i++) bits[i] = 1'b1;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = data[i];
      nb = 9;
      if (PAR_EN) begin
         bits[9] = pbit;
         nb = 10;
      end
      bits[nb] = sbit;
      lat = nb * p + p / 2 + 3;
      exp_pe = PAR_EN && (pbit != (PAR_TYP ? ~^data : ^data));
      exp_se = !sbit;
      exp_dv = !exp_pe && !exp_se;
      stray = 0;
      RX_IN = 1'b0;
      sampled = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         @(negedge CLK);
         if (c == abort_at) begin
            Reset = 1'b0;
            RX_IN = 1'b1;
            sampled = 1'b0;
            Sampled_bit = 1'b1;
            #1;
            chk_all_zero({tag, "_rst"});
            model_pdata = 8'h00;
            return;
         end
         if (c == 0) begin
            chk_val({tag, "_sen0"},  32'(S_EN),       32'd1);
            chk_val({tag, "_edge0"}, 32'(edge_count), 32'd0);
         end
         if (c == p + 3) chk_val({tag, "_edgemid"}, 32'(edge_count), 32'd3);
         if (c < lat) begin
            if (Data_valid || Par_err || Stp_err) stray++;
            RX_IN = bits[c / p];
            Sampled_bit = bits[c / p];
            sampled = ((c % p) == (p / 2 + 2));
         end else begin
            RX_IN = 1'b1;
            Sampled_bit = 1'b1;
            sampled = 1'b0;
         end
      end
      if (exp_dv) model_pdata = data;
      chk_val({tag, "_stray"}, 32'(stray),      32'd0);
      chk_val({tag, "_dv"},    32'(Data_valid), 32'(exp_dv));
      chk_val({tag, "_pe"},    32'(Par_err),    32'(exp_pe));
      chk_val({tag, "_se"},    32'(Stp_err),    32'(exp_se));
      chk_val({tag, "_pdat"},  32'(P_DATA),     32'(model_pdata));
      chk_val({tag, "_senend"}, 32'(S_EN),      32'd0);
   endtask

   initial begin
      int stray;
      repeat (3) @(negedge CLK);
      chk_all_zero("reset");
      Reset = 1'b1;
      idle_cycles(4);

      // 8N1, 0xA5: Data_valid lands at cycle 79
      Prescale = 5'd8;
      PAR_EN = 1'b0;
      run_frame("a5", 8'hA5, 1'b0, 1'b1, -1);
      chk_val("a5_pdat_lit", 32'(P_DATA), 32'h0000_00A5);
      idle_cycles(5);

      // even parity, 0x0F: parity bit 1 is wrong, 0 is right
      PAR_EN = 1'b1;
      PAR_TYP = 1'b0;
      run_frame("0f_bad", 8'h0F, 1'b1, 1'b1, -1);
      chk_val("0f_bad_keep", 32'(P_DATA), 32'h0000_00A5);
      idle_cycles(5);
      run_frame("0f_good", 8'h0F, 1'b0, 1'b1, -1);
      chk_val("0f_good_lit", 32'(P_DATA), 32'h0000_000F);
      idle_cycles(5);

      // Prescale 5, odd parity, 0x80 with correct parity 0 but broken stop
      Prescale = 5'd5;
      PAR_TYP = 1'b1;
      run_frame("80_stp", 8'h80, 1'b0, 1'b0, -1);
      idle_cycles(5);

      // start glitch: line low for the IDLE cycle and cycle 0 only
      Prescale = 5'd8;
      PAR_EN = 1'b0;
      PAR_TYP = 1'b0;
      stray = 0;
      RX_IN = 1'b0;
      for (int c = 0; c <= 7; c++) begin
         @(negedge CLK);
         if (Data_valid || Par_err || Stp_err) stray++;
         if (c == 3) chk_val("glitch_sen_mid", 32'(S_EN), 32'd1);
         if (c == 7) begin
            chk_val("glitch_sen_end",  32'(S_EN),       32'd0);
            chk_val("glitch_edge_end", 32'(edge_count), 32'd0);
         end
         RX_IN = (c < 1) ? 1'b0 : 1'b1;
         Sampled_bit = RX_IN;
         sampled = (c == 6);
      end
      idle_cycles(3);
      chk_val("glitch_stray", 32'(stray),  32'd0);
      chk_val("glitch_pdat",  32'(P_DATA), 32'(model_pdata));
      chk_val("glitch_idle",  32'(S_EN),   32'd0);

      // back-to-back: second start bit driven in the IDLE cycle after the stop sample
      run_frame("b2b_55", 8'h55, 1'b0, 1'b1, -1);
      run_frame("b2b_c3", 8'hC3, 1'b0, 1'b1, -1);
      chk_val("b2b_c3_lit", 32'(P_DATA), 32'h0000_00C3);
      idle_cycles(5);

      // reset in the middle of DATA, then a clean frame
      run_frame("mid", 8'h3C, 1'b0, 1'b1, 30);
      @(negedge CLK);
      chk_all_zero("rst_hold");
      Reset = 1'b1;
      idle_cycles(4);
      run_frame("post", 8'h96, 1'b0, 1'b1, -1);
      chk_val("post_lit", 32'(P_DATA), 32'h0000_0096);
      idle_cycles(3);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
